pooling_input_serializer: RTL
=============================

// Module: pooling_input_serializer
// PURPOSE
//  Parallel-in/serial-out front end of the pooling layer, parametrised in kernel size, data width and channel count.
//  Accepts one kernel row per channel (KERNEL_SIZE words each) under valid/ready handshake.
//  Emits one word per channel per beat, most-significant word first, with a last-word flag and the row's block_idx tag.
//  A holding register lets the next row be accepted while the current one drains, so back-to-back rows stream with no bubbles.
// PARAMETERS
//  DATA_WIDTH   32  bits per word (IEEE-754 single)
//  KERNEL_SIZE  2   words per channel per row; legal >= 2
//  NUM_CH       1   parallel channel lanes; legal >= 1
//  ROW_WIDTH    5   width of block_idx tag
// PORTS
//  clk            in   1                          clock, rising edge
//  rst            in   1                          synchronous, active-high reset
//  in_valid       in   1                          in_data/in_block_idx valid
//  in_ready       out  1                          block can accept a row
//  in_block_idx   in   ROW_WIDTH                  tag of the row
//  in_data        in   NUM_CH*KERNEL_SIZE*DATA_WIDTH  ch c = [(c+1)*K*DW-1 : c*K*DW]; word 0 = MS word of slice
//  out_valid      out  1                          out_data valid
//  out_ready      in   1                          downstream accepts
//  out_data       out  NUM_CH*DATA_WIDTH          ch c = [(c+1)*DW-1 : c*DW]
//  out_last       out  1                          current beat is word KERNEL_SIZE-1
//  out_block_idx  out  ROW_WIDTH                  tag of row being emitted
// BEHAVIOUR
//  - Clocking and reset: one clock, clk. rst is synchronous and active-high.
//  - Reset values: out_valid=0, out_last=0, out_data=0, out_block_idx=0, word cnt=0, hold empty, state EMPTY.
//    in_ready=0 while rst is high.
//  - Handshakes:
//    - in_fire  = in_valid & in_ready.
//    - out_fire = out_valid & out_ready.
//    - out_data, out_last and out_block_idx stay stable while out_valid & !out_ready.
//  - in_ready = !rst & !hold_valid. It is registered-state derived, with no combinational path from out_ready.
//  - States:
//    - EMPTY: shift register idle, hold empty.
//    - ACTIVE: shifting, hold empty.
//    - FULL: shifting, hold loaded.
//    - out_valid = (state != EMPTY).
//  - EMPTY:
//    - in_fire loads the shift register and tag.
//    - Next state ACTIVE, cnt=0.
//    - out_valid rises the cycle after in_fire (1-cycle latency).
//  - ACTIVE/FULL, out_fire with cnt<K-1:
//    - every lane shifts one word toward the output; the vacated tail word is zero-filled.
//    - cnt++.
//  - out_fire with cnt==K-1 (out_last=1):
//    - FULL: hold -> shift register and tag, cnt=0, next state ACTIVE.
//    - ACTIVE with in_fire in the same cycle: in_data loads the shift register directly, next state ACTIVE.
//    - ACTIVE without in_fire: next state EMPTY.
//  - in_fire in ACTIVE, not completing a row: in_data/tag -> hold, next state FULL.
//  - Simultaneous in_fire and last out_fire in FULL: impossible, because in_ready=0.
//  - out_last = out_valid & (cnt==KERNEL_SIZE-1).
//  - cnt width is $clog2(KERNEL_SIZE). It wraps to 0 only via reload; it never increments past K-1.
//  - Data is moved bit-exact; no arithmetic is performed.
//  - rst mid-row: the partial row and the hold contents are discarded. No output beat appears until a new in_fire.
//  - Stall: with out_ready=0 indefinitely, state, cnt and outputs are frozen. One further row may enter hold, then in_ready=0.
// STRUCTURE
//  - Shared package pooling_pkg:
//    - DATA_WIDTH, KERNEL_SIZE and ROW_WIDTH defaults.
//    - typedef word_t (logic [DATA_WIDTH-1:0]).
//    - enum ser_state_e {EMPTY, ACTIVE, FULL}.
//  - One sub-module, pooling_lane_shifter: a per-channel K-deep load/shift register with zero fill. It is instantiated NUM_CH times by generate.
//  - The top level holds the FSM, cnt, hold register and tag registers.
// TESTING
//  1. Reset/basic, K=2, NUM_CH=1:
//     - rst 2 cycles, then in_data={32'h3F800000,32'h40000000}, idx=3, out_ready=1.
//     - Expect 3F800000 (last=0), then 40000000 (last=1), both with idx=3.
//     - out_valid=0 afterward.
//  2. Streaming, K=2:
//     - 4 rows back-to-back, in_valid=1 and out_ready=1 throughout.
//     - Expect 8 consecutive out beats with no bubble, in order.
//     - in_ready never blocks for more than 1 cycle per row.
//  3. Backpressure:
//     - out_ready=0 for 5 cycles mid-row.
//     - Expect out_data/out_last/out_block_idx constant.
//     - The second row is accepted into hold, then in_ready=0.
//     - On release, all words emerge in order.
//  4. Multichannel, NUM_CH=2, K=3:
//     - ch0 = {1,2,3}, ch1 = {4,5,6}.
//     - Expect beats {ch1=4,ch0=1}, {5,2}, {6,3}.
//     - last on beat 3.
//  5. Reset mid-row:
//     - Assert rst after the first out beat of a K=2 row with hold loaded.
//     - Expect out_valid=0 the next cycle and no stale beat afterward.
//     - in_ready=1 once rst drops.
//  6. Random K∈{2,3,4}, random valid/ready toggling vs a scoreboard model: zero loss, zero duplication, tags match.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared types and defaults for the pooling layer input path.
package pooling_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned KERNEL_SIZE = 2;
    localparam int unsigned NUM_CH      = 1;
    localparam int unsigned ROW_WIDTH   = 5;

    // One IEEE-754 single word; moved bit-exact, never interpreted.
    typedef logic [DATA_WIDTH-1:0] word_t;

    // EMPTY: nothing to emit; ACTIVE: draining, hold free; FULL: draining, hold occupied.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/pooling_lane_shifter.sv
// One channel lane: a KERNEL_SIZE-deep word register, loaded in parallel and
// shifted toward the head (most-significant word) with zero fill at the tail.
module pooling_lane_shifter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KERNEL_SIZE = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic                              shift,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0]             head
);

    localparam int unsigned SrBits = KERNEL_SIZE * DATA_WIDTH;

    logic [SrBits-1:0] sr_q;

    // Parallel load has priority over shift so a new row can replace the last word at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            sr_q <= {sr_q[SrBits-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
        end
    end

    assign head = sr_q[SrBits-1 -: DATA_WIDTH];

endmodule

// File: rtl/pooling_input_serializer.sv
// Parallel-in/serial-out front end of the pooling layer. Accepts one kernel row
// per channel and emits it one word per channel per beat, MS word first, with a
// one-row holding register so consecutive rows stream without bubbles.
module pooling_input_serializer
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = pooling_pkg::DATA_WIDTH,
    parameter int unsigned KERNEL_SIZE = pooling_pkg::KERNEL_SIZE,
    parameter int unsigned NUM_CH      = pooling_pkg::NUM_CH,
    parameter int unsigned ROW_WIDTH   = pooling_pkg::ROW_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ROW_WIDTH-1:0]                   in_block_idx,
    input  logic [NUM_CH*KERNEL_SIZE*DATA_WIDTH-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]           out_data,
    output logic                                   out_last,
    output logic [ROW_WIDTH-1:0]                   out_block_idx
);

    localparam int unsigned CntW     = $clog2(KERNEL_SIZE);
    localparam int unsigned LaneBits = KERNEL_SIZE * DATA_WIDTH;
    localparam int unsigned RowBits  = NUM_CH * LaneBits;
    localparam logic [CntW-1:0] LastCnt = CntW'(KERNEL_SIZE - 1);

    ser_state_e           state_q;
    logic [CntW-1:0]      cnt_q;
    logic [RowBits-1:0]   hold_data_q;
    logic [ROW_WIDTH-1:0] hold_idx_q;
    logic [ROW_WIDTH-1:0] tag_q;

    logic               in_fire;
    logic               out_fire;
    logic               last_word;
    logic               sr_load;
    logic               sr_shift;
    logic [RowBits-1:0] sr_src;

    // Handshake and output flags, all derived from registered state (no out_ready path to in_ready).
    always_comb begin
        in_ready      = !rst && (state_q != FULL);
        out_valid     = (state_q != EMPTY);
        last_word     = (cnt_q == LastCnt);
        out_last      = out_valid && last_word;
        out_block_idx = tag_q;
        in_fire       = in_valid && in_ready;
        out_fire      = out_valid && out_ready;
    end

    // Shift register control: load on a fresh row (from idle, from hold, or direct
    // when the last word leaves while a row arrives); otherwise shift on each beat.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = out_fire;
        sr_src   = in_data;
        unique case (state_q)
            EMPTY:  sr_load = in_fire;
            ACTIVE: sr_load = out_fire && last_word && in_fire;
            FULL: begin
                sr_load = out_fire && last_word;
                sr_src  = hold_data_q;
            end
            default: sr_load = 1'b0;
        endcase
    end

    // Row FSM with word counter, hold register and tag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_idx_q  <= '0;
            tag_q       <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ACTIVE;
                        cnt_q   <= '0;
                        tag_q   <= in_block_idx;
                    end
                end
                ACTIVE: begin
                    if (out_fire && last_word) begin
                        cnt_q <= '0;
                        if (in_fire) begin
                            tag_q <= in_block_idx;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end else begin
                        if (out_fire) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                        if (in_fire) begin
                            hold_data_q <= in_data;
                            hold_idx_q  <= in_block_idx;
                            state_q     <= FULL;
                        end
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire && last_word) begin
                        cnt_q   <= '0;
                        tag_q   <= hold_idx_q;
                        state_q <= ACTIVE;
                    end else if (out_fire) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // One shifter per channel lane; the lane heads form the output beat.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        pooling_lane_shifter #(
            .DATA_WIDTH  (DATA_WIDTH),
            .KERNEL_SIZE (KERNEL_SIZE)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (sr_load),
            .shift     (sr_shift),
            .load_data (sr_src[c*LaneBits +: LaneBits]),
            .head      (out_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
